icache_line_fill: RTL and testbench
===================================

// Module: icache_line_fill
// PURPOSE
//  Line-fill engine directly downstream of the L1 I-cache miss port. Takes one
//  line request (strobe + address), issues one 8-beat INCR burst read on a
//  32-bit memory read channel, and assembles the beats into one 256-bit line.
//  Returns the line with a one-cycle ready pulse, in the I-cache's word order.
// PARAMETERS
//  XLEN    32   address and data-beat width
//  CLSIZE  256  cache line width in bits; beats per line = CLSIZE/XLEN (8)
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       asynchronous reset, active low
//  c_strobe_i   in   1       I-cache line request
//  c_addr_i     in   XLEN    request address (low 5 bits ignored)
//  c_ready_o    out  1       line valid, one-cycle pulse
//  c_data_o     out  CLSIZE  assembled line; word k at [CLSIZE-1-32k -: 32]
//  c_err_o      out  1       with c_ready_o: any beat had r_resp_i!=0 or bad last
//  ar_valid_o   out  1       burst address valid
//  ar_ready_i   in   1       burst address accepted
//  ar_addr_o    out  XLEN    line-aligned burst address
//  ar_len_o     out  8       beats-1 (constant 7)
//  r_valid_i    in   1       read beat valid
//  r_ready_o    out  1       read beat accepted
//  r_data_i     in   XLEN    read beat data
//  r_resp_i     in   2       beat response, 0 = OKAY
//  r_last_i     in   1       last beat marker
//  fill_cnt_o   out  32      completed fills   (ICFILL_PERF_EN only)
//  stall_cyc_o  out  32      cycles not in IDLE (ICFILL_PERF_EN only)
// BEHAVIOUR
//  - Reset (async, rst_ni=0): state IDLE; every output 0; beat_cnt 0; line buffer 0.
//    Reset mid-burst abandons the transaction; no drain.
//  - FSM IDLE -> ADDR -> DATA -> DONE -> HOLD -> IDLE.
//  - IDLE: c_strobe_i=1 latches {c_addr_i[XLEN-1:5],5'b0} into ar_addr_o; -> ADDR.
//  - ADDR: ar_valid_o=1, ar_addr_o/ar_len_o stable until ar_ready_i=1; -> DATA.
//    ar_ready_i high on first ADDR cycle: 1-cycle handshake.
//  - DATA: r_ready_o=1. Each r_valid_i beat writes word slot beat_cnt and
//    increments beat_cnt. ORs (r_resp_i!=0) into err. r_last_i on beat!=7, or
//    absent on beat 7, also sets err. beat_cnt alone ends the burst: on beat 7 -> DONE.
//  - DONE: c_ready_o=1 and c_err_o=err for exactly one cycle; c_data_o holds the
//    line from DONE until the next request is accepted. beat_cnt and err clear; -> HOLD.
//  - HOLD: one cycle, c_strobe_i ignored. The I-cache strobe is registered and
//    stays high one cycle after ready; HOLD stops a spurious refill. -> IDLE.
//  - c_strobe_i is ignored outside IDLE. An address change mid-fill has no effect.
//  - Latency, zero-wait memory: strobe@T -> ar_valid@T+1 -> beats T+2..T+9 ->
//    c_ready_o@T+10.
//  - r_valid_i outside DATA: r_ready_o=0, beat not consumed.
// CONFIGURATION
//  ICFILL_PERF_EN defined: ports fill_cnt_o, stall_cyc_o present.
//    - fill_cnt_o +1 per DONE; stall_cyc_o +1 per cycle state!=IDLE.
//    - Both wrap at 2^32 and reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package icache_pkg: state enum, WORDS_PER_LINE=8, LINE_OFS_BITS=5,
//    RESP_OKAY=2'b00.
//  - One sub-module, icfill_line_asm: beat_cnt, word-slot write decode, line
//    register, err accumulation. FSM and handshakes stay in icache_line_fill.
// TESTING
//  1. Zero-wait fill, c_addr_i=0x0000_1234, beats 0xA0..0xA7 ->
//     ar_addr_o=0x0000_1220, ar_len_o=7; c_ready_o@T+10;
//     c_data_o[255:224]=0xA0, [31:0]=0xA7; c_err_o=0.
//  2. ar_ready_i low 5 cycles, random r_valid_i gaps ->
//     ar_valid_o/ar_addr_o stable throughout; same line; exactly one c_ready_o pulse.
//  3. c_strobe_i held high 1 cycle past c_ready_o (I-cache timing) ->
//     no second ar_valid_o; next strobe in IDLE starts a new burst.
//  4. r_resp_i=2'b10 on beat 3; separately r_last_i on beat 5 ->
//     all 8 beats consumed; c_err_o=1 with c_ready_o; next clean fill c_err_o=0.
//  5. rst_ni low after beat 4 ->
//     all outputs 0 at once; next request fills a clean line, no stale words.
//  6. ICFILL_PERF_EN, three zero-wait fills -> fill_cnt_o=3, stall_cyc_o=33.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the I-cache line-fill engine.
package icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_HOLD
  } fill_state_t;

  localparam int         WORDS_PER_LINE = 8;
  localparam int         LINE_OFS_BITS  = 5;
  localparam logic [1:0] RESP_OKAY      = 2'b00;

endpackage

// File: rtl/icfill_line_asm.sv
// Beat counter, word-slot write decode, line register and error accumulation
// for one burst line fill.
module icfill_line_asm
  import icache_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              beat_i,
  input  logic              done_i,
  input  logic [XLEN-1:0]   r_data_i,
  input  logic [1:0]        r_resp_i,
  input  logic              r_last_i,
  output logic [CLSIZE-1:0] line_o,
  output logic              last_beat_o,
  output logic              err_o
);

  localparam int BEATS  = CLSIZE / XLEN;
  localparam int BEAT_W = $clog2(BEATS);

  logic [BEAT_W-1:0] beat_cnt_reg;
  logic              err_reg;
  logic              is_last;
  logic              beat_err;

  assign is_last     = (beat_cnt_reg == BEAT_W'(BEATS - 1));
  assign last_beat_o = beat_i & is_last;
  // r_last must coincide exactly with the final counted beat
  assign beat_err    = (r_resp_i != RESP_OKAY) | (r_last_i != is_last);
  assign err_o       = err_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else if (done_i) begin
      beat_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else if (beat_i) begin
      beat_cnt_reg <= beat_cnt_reg + 1'b1;
      err_reg      <= err_reg | beat_err;
    end
  end

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
      logic [XLEN-1:0] word_reg;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          word_reg <= '0;
        end else if (clear_i) begin
          word_reg <= '0;
        end else if (beat_i && (beat_cnt_reg == BEAT_W'(gi))) begin
          word_reg <= r_data_i;
        end
      end

      // word 0 sits in the most significant slot
      assign line_o[CLSIZE-1-XLEN*gi -: XLEN] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_line_fill.sv
// I-cache line-fill engine: one request -> one 8-beat INCR burst -> one line.
// Optional perf counters fill_cnt_o/stall_cyc_o under `define ICFILL_PERF_EN.
module icache_line_fill
  import icache_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              c_strobe_i,
  input  logic [XLEN-1:0]   c_addr_i,
  output logic              c_ready_o,
  output logic [CLSIZE-1:0] c_data_o,
  output logic              c_err_o,
  output logic              ar_valid_o,
  input  logic              ar_ready_i,
  output logic [XLEN-1:0]   ar_addr_o,
  output logic [7:0]        ar_len_o,
  input  logic              r_valid_i,
  output logic              r_ready_o,
  input  logic [XLEN-1:0]   r_data_i,
  input  logic [1:0]        r_resp_i,
  input  logic              r_last_i
`ifdef ICFILL_PERF_EN
  ,
  output logic [31:0]       fill_cnt_o,
  output logic [31:0]       stall_cyc_o
`endif
);

  localparam int              BEATS     = CLSIZE / XLEN;
  localparam logic [XLEN-1:0] LINE_MASK = XLEN'((1 << LINE_OFS_BITS) - 1);

  fill_state_t     state_reg, state_next;
  logic [XLEN-1:0] ar_addr_reg;
  logic            start;
  logic            beat;
  logic            last_beat;
  logic            err;

  assign start = (state_reg == ST_IDLE) & c_strobe_i;
  assign beat  = (state_reg == ST_DATA) & r_valid_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg   <= ST_IDLE;
      ar_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        ar_addr_reg <= c_addr_i & ~LINE_MASK;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (c_strobe_i) state_next = ST_ADDR;
      ST_ADDR: if (ar_ready_i) state_next = ST_DATA;
      ST_DATA: if (last_beat)  state_next = ST_DONE;
      ST_DONE: state_next = ST_HOLD;
      // the I-cache strobe lingers one cycle after ready; swallow it here
      ST_HOLD: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign ar_valid_o = (state_reg == ST_ADDR);
  assign ar_addr_o  = ar_addr_reg;
  assign ar_len_o   = 8'(BEATS - 1);
  assign r_ready_o  = (state_reg == ST_DATA);
  assign c_ready_o  = (state_reg == ST_DONE);
  assign c_err_o    = c_ready_o & err;

  icfill_line_asm #(
    .XLEN   (XLEN),
    .CLSIZE (CLSIZE)
  ) u_line_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (start),
    .beat_i      (beat),
    .done_i      (c_ready_o),
    .r_data_i    (r_data_i),
    .r_resp_i    (r_resp_i),
    .r_last_i    (r_last_i),
    .line_o      (c_data_o),
    .last_beat_o (last_beat),
    .err_o       (err)
  );

`ifdef ICFILL_PERF_EN
  logic [31:0] fill_cnt_reg;
  logic [31:0] stall_cyc_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_cnt_reg  <= '0;
      stall_cyc_reg <= '0;
    end else begin
      if (state_reg == ST_DONE) fill_cnt_reg <= fill_cnt_reg + 32'd1;
      if (state_reg != ST_IDLE) stall_cyc_reg <= stall_cyc_reg + 32'd1;
    end
  end

  assign fill_cnt_o  = fill_cnt_reg;
  assign stall_cyc_o = stall_cyc_reg;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed self-checking bench for icache_line_fill (define ICFILL_PERF_EN to
// also exercise the perf counters).
module tb_icache_line_fill;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         c_strobe = 1'b0;
  logic [31:0]  c_addr = '0;
  logic         c_ready;
  logic [255:0] c_data;
  logic         c_err;
  logic         ar_valid;
  logic         ar_ready = 1'b0;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [31:0]  r_data = '0;
  logic [1:0]   r_resp = '0;
  logic         r_last = 1'b0;
`ifdef ICFILL_PERF_EN
  logic [31:0]  fill_cnt;
  logic [31:0]  stall_cyc;
`endif

  int checks = 0;
  int errors = 0;
  int gap_tab[8] = '{1, 0, 2, 0, 3, 1, 0, 2};

  always #5 clk = ~clk;

  icache_line_fill dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .c_strobe_i  (c_strobe),
    .c_addr_i    (c_addr),
    .c_ready_o   (c_ready),
    .c_data_o    (c_data),
    .c_err_o     (c_err),
    .ar_valid_o  (ar_valid),
    .ar_ready_i  (ar_ready),
    .ar_addr_o   (ar_addr),
    .ar_len_o    (ar_len),
    .r_valid_i   (r_valid),
    .r_ready_o   (r_ready),
    .r_data_i    (r_data),
    .r_resp_i    (r_resp),
    .r_last_i    (r_last)
`ifdef ICFILL_PERF_EN
    ,
    .fill_cnt_o  (fill_cnt),
    .stall_cyc_o (stall_cyc)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".c_ready"},  c_ready,  0);
    check({tag, ".c_data"},   c_data,   0);
    check({tag, ".c_err"},    c_err,    0);
    check({tag, ".ar_valid"}, ar_valid, 0);
    check({tag, ".ar_addr"},  ar_addr,  0);
    check({tag, ".r_ready"},  r_ready,  0);
  endtask

  // One full fill. resp_beat/last_beat select which beat carries SLVERR / r_last.
  task automatic do_fill(input string name, input logic [31:0] addr, input int ar_delay,
                         input bit gaps, input int resp_beat, input int last_beat,
                         input logic [31:0] base, input bit exp_err, input bit hold_strobe);
    int           edges;
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    edges    = 0;
    exp_addr = addr & 32'hFFFF_FFE0;
    for (int k = 0; k < 8; k++) exp_line[255-32*k -: 32] = base + 32'(k);

    c_strobe = 1'b1;
    c_addr   = addr;
    tick(); edges++;
    c_strobe = 1'b0;
    c_addr   = 32'hDEAD_BEEF;  // address change mid-fill must be ignored

    for (int i = 0; i < ar_delay; i++) begin
      r_valid = 1'b1;          // stray beat before DATA must not be consumed
      r_data  = 32'hBAD0_0000 + 32'(i);
      check({name, ".ar_valid_wait"}, ar_valid, 1);
      check({name, ".ar_addr_wait"},  ar_addr,  exp_addr);
      check({name, ".r_ready_addr"},  r_ready,  0);
      tick(); edges++;
    end
    r_valid = 1'b0;
    check({name, ".ar_valid"}, ar_valid, 1);
    check({name, ".ar_addr"},  ar_addr,  exp_addr);
    check({name, ".ar_len"},   ar_len,   8'd7);
    ar_ready = 1'b1;
    tick(); edges++;
    ar_ready = 1'b0;
    check({name, ".ar_valid_drop"}, ar_valid, 0);

    for (int b = 0; b < 8; b++) begin
      if (gaps) begin
        for (int g = 0; g < gap_tab[b]; g++) begin
          r_valid = 1'b0;
          check({name, ".c_ready_gap"}, c_ready, 0);
          tick(); edges++;
        end
      end
      r_valid = 1'b1;
      r_data  = base + 32'(b);
      r_resp  = (b == resp_beat) ? 2'b10 : 2'b00;
      r_last  = (b == last_beat);
      check({name, ".r_ready"}, r_ready, 1);
      tick(); edges++;
    end
    r_valid = 1'b0;
    r_resp  = 2'b00;
    r_last  = 1'b0;
    if (hold_strobe) c_strobe = 1'b1;

    check({name, ".c_ready"}, c_ready, 1);
    check({name, ".c_err"},   c_err,   exp_err);
    check({name, ".c_data"},  c_data,  exp_line);
    if (ar_delay == 0 && !gaps) check({name, ".latency"}, edges, 10);

    tick();
    check({name, ".c_ready_pulse"}, c_ready,  0);
    check({name, ".c_err_pulse"},   c_err,    0);
    check({name, ".c_data_hold"},   c_data,   exp_line);
    check({name, ".ar_valid_hold"}, ar_valid, 0);
    tick();
    c_strobe = 1'b0;
    check({name, ".ar_valid_idle"}, ar_valid, 0);
    tick();
    check({name, ".no_refill"}, ar_valid, 0);
    check({name, ".c_data_idle"}, c_data, exp_line);
    $display("fill %s addr=%h line=%h err=%0d", name, exp_addr, c_data, c_err);
  endtask

  initial begin
    tick();
    tick();
    check_all_zero("reset");
`ifdef ICFILL_PERF_EN
    check("reset.fill_cnt",  fill_cnt,  0);
    check("reset.stall_cyc", stall_cyc, 0);
`endif
    rst_n = 1'b1;
    tick();

    do_fill("t1_zero_wait", 32'h0000_1234, 0, 1'b0, -1, 7, 32'h0000_00A0, 1'b0, 1'b0);
    check("t1.word0", c_data[255:224], 32'h0000_00A0);
    check("t1.word7", c_data[31:0],    32'h0000_00A7);

    do_fill("t2_stalls", 32'h8000_00FF, 5, 1'b1, -1, 7, 32'h1111_0000, 1'b0, 1'b0);
    do_fill("t3_held_strobe", 32'h0000_4040, 0, 1'b0, -1, 7, 32'h2222_0000, 1'b0, 1'b1);
    do_fill("t3_next", 32'h0000_5000, 0, 1'b0, -1, 7, 32'h3333_0000, 1'b0, 1'b0);
    do_fill("t4_resp_err", 32'h0000_6060, 0, 1'b0, 3, 7, 32'h4444_0000, 1'b1, 1'b0);
    do_fill("t4_last_err", 32'h0000_7070, 0, 1'b1, -1, 5, 32'h5555_0000, 1'b1, 1'b0);
    do_fill("t4_clean", 32'h0000_8080, 0, 1'b0, -1, 7, 32'h6666_0000, 1'b0, 1'b0);

    // Reset after beat 4 of a burst
    c_strobe = 1'b1;
    c_addr   = 32'h0000_9090;
    tick();
    c_strobe = 1'b0;
    ar_ready = 1'b1;
    tick();
    ar_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      r_valid = 1'b1;
      r_data  = 32'h7777_0000 + 32'(b);
      tick();
    end
    r_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check_all_zero("t5_reset");
`ifdef ICFILL_PERF_EN
    check("t5.fill_cnt_rst",  fill_cnt,  0);
    check("t5.stall_cyc_rst", stall_cyc, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    do_fill("t5_after_reset", 32'h0000_A0A0, 0, 1'b0, -1, 7, 32'h8888_0000, 1'b0, 1'b0);
`ifdef ICFILL_PERF_EN
    do_fill("t6_perf_b", 32'h0000_B0B0, 0, 1'b0, -1, 7, 32'h9999_0000, 1'b0, 1'b0);
    do_fill("t6_perf_c", 32'h0000_C0C0, 0, 1'b0, -1, 7, 32'hAAAA_0000, 1'b0, 1'b0);
    check("t6.fill_cnt",  fill_cnt,  3);
    check("t6.stall_cyc", stall_cyc, 33);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
